// File: rtl/calc_seq_ctrl.sv
// Calculator sequencer: synchronised key events drive a capture/start/wait/show FSM for the ALU and display.
// Define CALC_CHAIN_EN to let an op key in SHOW chain the previous result into operand A.
module calc_seq_ctrl #(
  parameter int W       = 8,
  parameter int TIMEOUT = 1023,
  parameter int SYNC    = 2
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic [W-1:0] sw,
  input  logic         key_a,
  input  logic         key_b,
  input  logic [3:0]   arifs,
  input  logic         clr,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [1:0]   alu_op,
  output logic         alu_start,
  input  logic         alu_done,
  input  logic [W-1:0] alu_res,
  input  logic [2:0]   alu_code,
  output logic [W-1:0] disp_data,
  output logic [2:0]   disp_code,
  output logic         busy
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_OP, S_WAIT_B, S_START, S_WAIT_DONE, S_SHOW
  } state_t;

  state_t          r_state;
  logic [6:0]      r_sync [SYNC];
  logic [6:0]      r_last;
  logic [CW-1:0]   r_cnt;
  logic [W-1:0]    r_alu_a;
  logic [W-1:0]    r_alu_b;
  logic [1:0]      r_alu_op;
  logic            r_alu_start;
  logic [W-1:0]    r_disp_data;
  logic [2:0]      r_disp_code;
  logic            r_busy;

  logic [6:0]      w_keys;
  logic [6:0]      w_ev;
  logic            w_ev_a;
  logic            w_ev_b;
  logic            w_ev_op;
  logic            w_ev_clr;
  logic [1:0]      w_op;
  logic [CW-1:0]   w_cnt_inc;
  logic            w_tmo;

  assign w_keys   = {clr, arifs, key_b, key_a};
  assign w_ev     = r_sync[SYNC-1] & ~r_last;
  assign w_ev_a   = w_ev[0];
  assign w_ev_b   = w_ev[1];
  assign w_ev_op  = |w_ev[5:2];
  assign w_ev_clr = w_ev[6];

  // lowest pressed op key wins when several are down together
  always_comb begin
    w_op = 2'd0;
    if (r_sync[SYNC-1][5]) w_op = 2'd3;
    if (r_sync[SYNC-1][4]) w_op = 2'd2;
    if (r_sync[SYNC-1][3]) w_op = 2'd1;
    if (r_sync[SYNC-1][2]) w_op = 2'd0;
  end

  assign w_cnt_inc = (r_cnt == CW'(TIMEOUT)) ? r_cnt : r_cnt + CW'(1);
  assign w_tmo     = (w_cnt_inc == CW'(TIMEOUT));

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int i = 0; i < SYNC; i++) r_sync[i] <= '0;
      r_last <= '0;
    end else begin
      r_sync[0] <= w_keys;
      for (int i = 1; i < SYNC; i++) r_sync[i] <= r_sync[i-1];
      r_last <= r_sync[SYNC-1];
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_op    <= 2'd0;
      r_alu_start <= 1'b0;
      r_disp_data <= '0;
      r_disp_code <= 3'd0;
      r_busy      <= 1'b0;
    end else begin
      r_alu_start <= 1'b0;
      if (w_ev_clr) begin
        r_state     <= S_IDLE;
        r_cnt       <= '0;
        r_alu_op    <= 2'd0;
        r_disp_data <= '0;
        r_disp_code <= 3'd0;
        r_busy      <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_disp_data <= sw;
            r_disp_code <= 3'd0;
            if (w_ev_a) begin
              r_alu_a <= sw;
              r_state <= S_WAIT_OP;
            end
          end
          S_WAIT_OP: begin
            if (w_ev_a) begin
              r_alu_a     <= sw;
              r_disp_data <= sw;
            end else if (w_ev_op) begin
              r_alu_op    <= w_op;
              r_disp_data <= sw;
              r_state     <= S_WAIT_B;
            end else begin
              r_disp_data <= r_alu_a;
            end
          end
          S_WAIT_B: begin
            r_disp_data <= sw;
            if (w_ev_op) r_alu_op <= w_op;
            if (w_ev_b) begin
              r_alu_b     <= sw;
              r_alu_start <= 1'b1;
              r_busy      <= 1'b1;
              r_state     <= S_START;
            end
          end
          S_START: begin
            r_cnt   <= '0;
            r_state <= S_WAIT_DONE;
          end
          S_WAIT_DONE: begin
            r_cnt <= w_cnt_inc;
            if (alu_done) begin
              r_disp_data <= alu_res;
              r_disp_code <= alu_code;
              r_busy      <= 1'b0;
              r_state     <= S_SHOW;
            end else if (w_tmo) begin
              r_disp_data <= '0;
              r_disp_code <= 3'd3;
              r_busy      <= 1'b0;
              r_state     <= S_SHOW;
            end
          end
          S_SHOW: begin
            if (w_ev_a) begin
              r_alu_a     <= sw;
              r_disp_data <= sw;
              r_disp_code <= 3'd0;
              r_state     <= S_WAIT_OP;
            end
`ifdef CALC_CHAIN_EN
            else if (w_ev_op && r_disp_code == 3'd0) begin
              r_alu_a     <= r_disp_data;
              r_alu_op    <= w_op;
              r_disp_data <= sw;
              r_state     <= S_WAIT_B;
            end
`else
            // op keys are dead here; a new calculation starts from key_a
`endif
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_op    = r_alu_op;
  assign alu_start = r_alu_start;
  assign disp_data = r_disp_data;
  assign disp_code = r_disp_code;
  assign busy      = r_busy;

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Directed bench for calc_seq_ctrl with a behavioural ALU responder and hand-computed expectations.
module tb_calc_seq_ctrl;
  localparam int W = 8;
  localparam logic [6:0] KA  = 7'b0000001;
  localparam logic [6:0] KB  = 7'b0000010;
  localparam logic [6:0] OP0 = 7'b0000100;
  localparam logic [6:0] OP1 = 7'b0001000;
  localparam logic [6:0] OP2 = 7'b0010000;
  localparam logic [6:0] OP3 = 7'b0100000;
  localparam logic [6:0] CLR = 7'b1000000;

  logic         Clk = 1'b0;
  logic         Rst;
  logic [W-1:0] sw;
  logic [6:0]   keys;
  logic         key_a, key_b, clr;
  logic [3:0]   arifs;
  logic [W-1:0] alu_a, alu_b, alu_res, disp_data;
  logic [1:0]   alu_op;
  logic         alu_start, alu_done, busy;
  logic [2:0]   alu_code, disp_code;

  assign key_a = keys[0];
  assign key_b = keys[1];
  assign arifs = keys[5:2];
  assign clr   = keys[6];

  calc_seq_ctrl #(.W(W), .TIMEOUT(15), .SYNC(2)) dut (
    .Clk(Clk), .Rst(Rst), .sw(sw), .key_a(key_a), .key_b(key_b), .arifs(arifs), .clr(clr),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_start(alu_start),
    .alu_done(alu_done), .alu_res(alu_res), .alu_code(alu_code),
    .disp_data(disp_data), .disp_code(disp_code), .busy(busy)
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0, t_start = 0, t_show = 0, n_start = 0, s0;
  logic [2:0] prev_code = 3'd0;
  int resp_dly = 5;
  logic [W-1:0] resp_res = '0;
  logic [2:0] resp_code = 3'd0;
  bit resp_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic press(input logic [6:0] m, input int hold);
    keys = m;
    repeat (hold) @(negedge Clk);
    keys = '0;
    repeat (5) @(negedge Clk);
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge Clk);
  endtask

  initial begin
    forever begin
      @(negedge Clk);
      if (alu_start === 1'b1) begin
        n_start++;
        t_start = cyc;
      end
      if (disp_code == 3'd3 && prev_code != 3'd3) t_show = cyc;
      prev_code = disp_code;
      cyc++;
    end
  end

  initial begin
    alu_done = 1'b0;
    alu_res  = '0;
    alu_code = 3'd0;
    forever begin
      @(negedge Clk);
      if (alu_start === 1'b1 && resp_en) begin
        repeat (resp_dly - 1) @(negedge Clk);
        alu_done = 1'b1;
        alu_res  = resp_res;
        alu_code = resp_code;
        @(negedge Clk);
        alu_done = 1'b0;
        alu_res  = '0;
        alu_code = 3'd0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    Rst = 1'b1;
    keys = '0;
    sw = 8'h5A;
    settle(3);
    chk("rst_disp_data", disp_data, 0);
    chk("rst_disp_code", disp_code, 0);
    chk("rst_busy", busy, 0);
    chk("rst_alu_start", alu_start, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_op", alu_op, 0);
    Rst = 1'b0;
    settle(2);
    chk("idle_follows_sw", disp_data, 8'h5A);

    // basic add 25 + 17
    sw = 8'd25;
    press(KA, 1);
    chk("a_latched", alu_a, 25);
    chk("wait_op_disp", disp_data, 25);
    sw = 8'd0;
    press(OP0, 1);
    chk("op_add", alu_op, 0);
    sw = 8'd17;
    settle(2);
    chk("wait_b_disp", disp_data, 17);
    resp_en = 1'b1; resp_dly = 5; resp_res = 8'd42; resp_code = 3'd0;
    s0 = n_start;
    press(KB, 1);
    settle(12);
    chk("add_one_start", n_start - s0, 1);
    chk("add_alu_a", alu_a, 25);
    chk("add_alu_b", alu_b, 17);
    chk("add_alu_op", alu_op, 0);
    chk("add_disp", disp_data, 42);
    chk("add_code", disp_code, 0);
    chk("add_busy", busy, 0);

    // multi-bit op select and long key_b hold
    sw = 8'd9;
    press(KA, 1);
    chk("show_key_a", alu_a, 9);
    press(OP1 | OP3, 1);
    chk("lowest_op", alu_op, 1);
    sw = 8'd3; resp_res = 8'd6;
    s0 = n_start;
    keys = KB;
    settle(100);
    keys = '0;
    settle(6);
    chk("held_kb_one_start", n_start - s0, 1);
    chk("sub_disp", disp_data, 6);

    // key_a and op together in WAIT_OP
    sw = 8'd11;
    press(KA, 1);
    sw = 8'd77;
    press(KA | OP2, 1);
    chk("simul_relatch_a", alu_a, 77);
    chk("simul_op_ignored", alu_op, 1);
    sw = 8'd5;
    settle(2);
    chk("simul_still_wait_op", disp_data, 77);

    // divide by zero
    press(OP3, 1);
    chk("op_div", alu_op, 3);
    sw = 8'd0; resp_res = 8'd0; resp_code = 3'd2;
    press(KB, 1);
    settle(12);
    chk("div0_code", disp_code, 2);
    chk("div0_alu_b", alu_b, 0);
    press(OP0, 1);
    chk("div0_op_ignored", alu_op, 3);
    chk("div0_code_held", disp_code, 2);

    // chained calculation from a plain result
    sw = 8'd39;
    press(KA, 1);
    press(OP0, 1);
    sw = 8'd3; resp_res = 8'd42; resp_code = 3'd0;
    press(KB, 1);
    settle(12);
    chk("chain_base_disp", disp_data, 42);
    sw = 8'd2;
    press(OP2, 1);
    resp_res = 8'd84;
    s0 = n_start;
    press(KB, 1);
    settle(12);
`ifdef CALC_CHAIN_EN
    chk("chain_alu_a", alu_a, 42);
    chk("chain_alu_op", alu_op, 2);
    chk("chain_alu_b", alu_b, 2);
    chk("chain_start", n_start - s0, 1);
    chk("chain_disp", disp_data, 84);
`else
    chk("nochain_alu_a", alu_a, 39);
    chk("nochain_alu_op", alu_op, 0);
    chk("nochain_alu_b", alu_b, 3);
    chk("nochain_start", n_start - s0, 0);
    chk("nochain_disp", disp_data, 42);
`endif

    // clr beats a simultaneous key_b
    sw = 8'd5;
    press(KA, 1);
    press(OP1, 1);
    sw = 8'd6;
    s0 = n_start;
    press(CLR | KB, 1);
    chk("clr_no_start", n_start - s0, 0);
    chk("clr_alu_op", alu_op, 0);
    chk("clr_code", disp_code, 0);
    chk("clr_idle_disp", disp_data, 6);
    chk("clr_busy", busy, 0);
    chk("clr_keeps_a", alu_a, 5);

    // clr while waiting drops the late result
    sw = 8'd7;
    press(KA, 1);
    press(OP0, 1);
    sw = 8'd8; resp_dly = 10; resp_res = 8'd99;
    press(KB, 1);
    chk("wait_done_busy", busy, 1);
    press(CLR, 1);
    settle(10);
    chk("clr_drop_disp", disp_data, 8);
    chk("clr_drop_code", disp_code, 0);
    chk("clr_drop_busy", busy, 0);

    // timeout with no alu_done
    resp_en = 1'b0;
    sw = 8'd1;
    press(KA, 1);
    press(OP0, 1);
    sw = 8'd2;
    press(KB, 1);
    settle(25);
    chk("tmo_latency", t_show - t_start, 16);
    chk("tmo_code", disp_code, 3);
    chk("tmo_disp", disp_data, 0);
    chk("tmo_busy", busy, 0);

    // async reset during WAIT_DONE
    resp_en = 1'b1; resp_dly = 10; resp_res = 8'h77; resp_code = 3'd1;
    sw = 8'h33;
    press(KA, 1);
    press(OP1, 1);
    press(KB, 1);
    chk("pre_rst_busy", busy, 1);
    Rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_start", alu_start, 0);
    chk("arst_disp", disp_data, 0);
    chk("arst_alu_a", alu_a, 0);
    @(negedge Clk);
    Rst = 1'b0;
    settle(12);
    chk("post_rst_disp", disp_data, 8'h33);
    chk("post_rst_code", disp_code, 0);
    chk("post_rst_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
